// File: rtl/pipeline_display_driver_if.sv
// Bus bundle for the pipeline display driver: pipeline-side inputs and the
// segment/enable/frame outputs of the 8-digit scanned display.
interface pipeline_display_driver_if;
    logic [15:0] PCValue;
    logic [15:0] WriteData;
    logic        Freeze;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic        FrameDone;

    modport master (
        output PCValue,
        output WriteData,
        output Freeze,
        input  out7,
        input  en_out,
        input  FrameDone
    );

    modport slave (
        input  PCValue,
        input  WriteData,
        input  Freeze,
        output out7,
        output en_out,
        output FrameDone
    );
endinterface

// File: rtl/pipeline_display_driver.sv
// Scans a frozen-per-frame snapshot of WriteData/PCValue over 8 active-low hex digits.
// Optional leading-zero blanking per 4-digit group: define DISPLAY_LEADING_ZERO_BLANK_EN.
module pipeline_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input logic                      Clk,
    input logic                      Reset,
    pipeline_display_driver_if.slave dd
);
    localparam logic [16:0] TERM_CNT = 17'(REFRESH_DIV - 1);

    logic [16:0] cnt_r;
    logic [2:0]  idx_r;
    logic [15:0] pc_snap_r;
    logic [15:0] wd_snap_r;
    logic        load_r;
    logic        frame_done_r;
    logic [6:0]  out7_r;
    logic [7:0]  en_out_r;

    logic        tc_s;
    logic        wrap_s;
    logic [15:0] group_s;
    logic [3:0]  nib_s;
    logic [6:0]  seg_s;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            4'hF:    hex7 = 7'b0001110;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every nibble above it in its group are zero.
    function automatic logic lead_zero(input logic [15:0] grp, input logic [1:0] pos);
        case (pos)
            2'd1:    lead_zero = (grp[15:4] == 12'h000);
            2'd2:    lead_zero = (grp[15:8] == 8'h00);
            2'd3:    lead_zero = (grp[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    endfunction
`endif

    // Terminal count, frame wrap and the segment pattern for the current digit.
    always_comb begin
        tc_s    = (cnt_r == TERM_CNT);
        wrap_s  = tc_s && (idx_r == 3'd7);
        group_s = idx_r[2] ? pc_snap_r : wd_snap_r;
        nib_s   = 4'h0;
        case (idx_r[1:0])
            2'd0:    nib_s = group_s[3:0];
            2'd1:    nib_s = group_s[7:4];
            2'd2:    nib_s = group_s[11:8];
            2'd3:    nib_s = group_s[15:12];
            default: nib_s = 4'h0;
        endcase
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if (lead_zero(group_s, idx_r[1:0])) begin
            seg_s = 7'b1111111;
        end else begin
            seg_s = hex7(nib_s);
        end
`else
        seg_s = hex7(nib_s);
`endif
    end

    // Refresh divider and digit index.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_r <= 17'd0;
            idx_r <= 3'd0;
        end else begin
            cnt_r <= tc_s ? 17'd0 : cnt_r + 17'd1;
            if (tc_s) begin
                idx_r <= idx_r + 3'd1;
            end
        end
    end

    // Snapshot is only taken at a frame boundary so a frame never mixes two values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_snap_r <= 16'h0000;
            wd_snap_r <= 16'h0000;
        end else if (wrap_s && !dd.Freeze) begin
            pc_snap_r <= dd.PCValue;
            wd_snap_r <= dd.WriteData;
        end
    end

    // Output stage; FrameDone is delayed to line up with the first digit of the new frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            load_r       <= 1'b0;
            frame_done_r <= 1'b0;
            out7_r       <= 7'b1111111;
            en_out_r     <= 8'hFF;
        end else begin
            load_r       <= wrap_s;
            frame_done_r <= load_r;
            out7_r       <= seg_s;
            en_out_r     <= ~(8'd1 << idx_r);
        end
    end

    assign dd.out7      = out7_r;
    assign dd.en_out    = en_out_r;
    assign dd.FrameDone = frame_done_r;
endmodule

// File: tb/tb_pipeline_display_driver.sv
// Directed bench for pipeline_display_driver with REFRESH_DIV=4 (one frame = 32 clocks).
module tb_pipeline_display_driver;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BLANK;
`else
    localparam logic [6:0] LZ = SEG_0;
`endif

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;
    int   ecount;
    logic [6:0] f1_seg [8];
    logic [7:0] en_exp;

    pipeline_display_driver_if dd ();

    pipeline_display_driver #(.REFRESH_DIV(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dd    (dd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after edge number tgt counted from reset release.
    task automatic goto_edge(input int tgt);
        while (ecount < tgt) begin
            @(posedge Clk);
            ecount++;
        end
        #1;
    endtask

    task automatic check_digit(input string tag, input int tgt, input logic [7:0] en_v,
                               input logic [6:0] seg_v, input logic fd_v);
        goto_edge(tgt);
        check_val({tag, "_en"}, {24'h0, dd.en_out}, {24'h0, en_v});
        check_val({tag, "_seg"}, {25'h0, dd.out7}, {25'h0, seg_v});
        check_val({tag, "_fd"}, {31'h0, dd.FrameDone}, {31'h0, fd_v});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ecount = 0;
        f1_seg[0] = SEG_F; f1_seg[1] = SEG_A; f1_seg[2] = LZ;    f1_seg[3] = LZ;
        f1_seg[4] = SEG_4; f1_seg[5] = SEG_3; f1_seg[6] = SEG_2; f1_seg[7] = SEG_1;

        Reset        = 1'b1;
        dd.PCValue   = 16'h1234;
        dd.WriteData = 16'h00AF;
        dd.Freeze    = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_seg", {25'h0, dd.out7}, {25'h0, BLANK});
        check_val("rst_en", {24'h0, dd.en_out}, 32'h0000_00FF);
        check_val("rst_fd", {31'h0, dd.FrameDone}, 32'h0);
        Reset = 1'b0;

        // Frame 0 shows the zeroed reset snapshot.
        check_digit("first", 1, 8'hFE, SEG_0, 1'b0);
        check_digit("f0_d7", 32, 8'h7F, LZ, 1'b0);

        // Frame 1: snapshot 1234/00AF; WriteData changes mid-frame without visible effect.
        for (int k = 0; k < 8; k++) begin
            en_exp = ~(8'd1 << k);
            check_digit($sformatf("f1_d%0d", k), 33 + 4 * k, en_exp, f1_seg[k], (k == 0));
            if (k == 1) dd.WriteData = 16'h8888;
        end
        check_digit("f1_end", 64, 8'h7F, SEG_1, 1'b0);
        check_digit("f2_d0", 65, 8'hFE, SEG_8, 1'b1);
        check_digit("f2_fd_off", 66, 8'hFE, SEG_8, 1'b0);
        check_digit("f2_d4", 81, 8'hEF, SEG_4, 1'b0);

        // Frame 2 end with Freeze high: snapshot held, FrameDone still pulses.
        dd.Freeze    = 1'b1;
        dd.WriteData = 16'h0005;
        dd.PCValue   = 16'h00C0;
        check_digit("frz_d0", 97, 8'hFE, SEG_8, 1'b1);
        check_digit("frz_fd_off", 98, 8'hFE, SEG_8, 1'b0);
        dd.Freeze = 1'b0;
        check_digit("frz_d4", 113, 8'hEF, SEG_4, 1'b0);

        // Frame 4: update after Freeze release.
        check_digit("f4_d0", 129, 8'hFE, SEG_5, 1'b1);
        check_digit("f4_d1", 133, 8'hFD, LZ, 1'b0);
        check_digit("f4_d4", 145, 8'hEF, SEG_0, 1'b0);
        check_digit("f4_d5", 149, 8'hDF, SEG_C, 1'b0);
        check_digit("f4_d6", 153, 8'hBF, LZ, 1'b0);
        check_digit("f4_d7", 157, 8'h7F, LZ, 1'b0);

        // Frame 5: reset at index 5 aborts the frame.
        check_digit("f5_d5", 181, 8'hDF, SEG_C, 1'b0);
        Reset = 1'b1;
        check_digit("mid_rst", 182, 8'hFF, BLANK, 1'b0);
        Reset = 1'b0;
        check_digit("rs_d0", 183, 8'hFE, SEG_0, 1'b0);
        check_digit("rs_d0_end", 186, 8'hFE, SEG_0, 1'b0);
        check_digit("rs_d1", 187, 8'hFD, LZ, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_display_driver.md
PIPELINE_DISPLAY_DRIVER -- requirements
Module: pipeline_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit; legal range 2..131071.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PCValue  input  16  low half of the PC of the instruction in the MEM/WB stage.
REQ-005 WriteData  input  16  low half of the write-back data.
REQ-006 Freeze  input  1  while high, the displayed snapshot is held.
REQ-007 out7  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 en_out  output  8  digit enables, active-low, one-hot-low.
REQ-009 FrameDone  output  1  one-cycle pulse when a snapshot load is attempted at frame end.

Function
REQ-010 Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0; the terminal count is REFRESH_DIV-1.
REQ-011 Digit index (3 bits) increments on each terminal count and wraps 7->0.
REQ-012 Digit map: index 0..3 = WriteData snapshot nibbles [3:0],[7:4],[11:8],[15:12]; index 4..7 = PCValue snapshot nibbles [3:0]..[15:12].
REQ-013 Snapshot registers (2 x 16 bits) load PCValue and WriteData only when the index wraps 7->0 and Freeze is low, so no frame mixes values.
REQ-014 FrameDone pulses high for exactly one cycle on every 7->0 wrap, whatever the level of Freeze.
REQ-015 Freeze high at the wrap: the snapshot is unchanged and FrameDone still pulses.
REQ-016 en_out and out7 are registered and reflect the new index one cycle after the terminal-count edge.
REQ-017 en_out = ~(8'b1 << index); exactly one bit is low whenever the block is not in reset.
REQ-018 Hex encoding, active-low, gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 Inputs PCValue and WriteData are sampled only at snapshot load; changes between loads have no visible effect.
REQ-020 The block is a pure sink: no output feeds back into the datapath.

Reset
REQ-021 While Reset is high at a rising edge, the next state is as follows:
- refresh counter = 0, index = 0, both snapshots = 16'h0000;
- FrameDone = 0, out7 = 7'b1111111, en_out = 8'hFF.
REQ-022 On the first edge after Reset deasserts: en_out = 8'hFE and out7 = 7'b1000000.
REQ-023 Reset asserted mid-frame aborts the frame, so the next frame starts at index 0 with zeroed snapshots.
REQ-024 Reset overrides Freeze and the terminal count when they occur on the same edge.

Configuration
REQ-025 Macro DISPLAY_LEADING_ZERO_BLANK_EN.
REQ-026 When defined, each 4-digit group blanks leading zero nibbles: out7 = 7'b1111111 for a digit that is zero and that has only zero nibbles above it in its group. The enable still scans, and digit 0 and digit 4 are never blanked.
REQ-027 When undefined, all eight digits always show their hex value, including leading zeros.

Verification
REQ-028 Bench uses REFRESH_DIV=4.
REQ-029 Reset held 3 cycles, then released -> out7=7'b1111111 and en_out=8'hFF during reset; first post-reset edge gives en_out=8'hFE and out7=7'b1000000.
REQ-030 PCValue=16'h1234, WriteData=16'h00AF, Freeze=0, two full frames -> second frame digits 0..7 show F,A,0,0,4,3,2,1. With the macro defined, digits 2 and 3 show 1111111.
REQ-031 Change WriteData to 16'h8888 mid-frame -> the current frame still shows old values; new values appear only after the next 7->0 wrap, coincident with the FrameDone pulse.
REQ-032 Freeze=1 across a wrap with new inputs -> snapshot unchanged and FrameDone pulses once. Release Freeze -> update at the following wrap.
REQ-033 Assert Reset at index 5 -> the next edge gives blank outputs; after release the scan restarts at en_out=8'hFE and the index advances every 4 cycles.
